// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Shared UART frame states, parity modes and data-length limits (RX and TX).
// Rev    : 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  localparam logic c_PAR_EVEN = 1'b0;
  localparam logic c_PAR_ODD  = 1'b1;

  localparam logic [3:0] c_NBITS_MIN = 4'd5;
  localparam logic [3:0] c_NBITS_MAX = 4'd9;

  function automatic logic [3:0] clamp_nbits(input logic [3:0] nbits, input logic [3:0] nmax);
    if (nbits < c_NBITS_MIN) return c_NBITS_MIN;
    if (nbits > nmax)        return nmax;
    return nbits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_param_if
// Received-word handshake between the UART receiver and its consumer.
// Rev    : 1.0
// ============================================================================
interface uart_rx_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] RxData;
  logic              RxValid;
  logic              RxReady;
  logic              ParityErr;
  logic              FrameErr;
  logic              Overrun;

  modport master (
    output RxData, RxValid, ParityErr, FrameErr, Overrun,
    input  RxReady
  );

  modport slave (
    input  RxData, RxValid, ParityErr, FrameErr, Overrun,
    output RxReady
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_sampler
// Rx synchroniser, oversample tick counter and 3-sample mid-bit majority vote.
// Rev    : 1.0
// ============================================================================
module uart_rx_sampler #(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire  Clk,
  input  wire  Rst_n,
  input  wire  Tick,
  input  wire  Rx,
  input  wire  cnt_clr,
  input  wire  cnt_run,
  output logic rx_s,
  output logic start_edge,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_end
);
  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] c_MID_LO = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] c_MID    = CW'(OVS/2);
  localparam logic [CW-1:0] c_MID_HI = CW'(OVS/2 + 1);
  localparam logic [CW-1:0] c_LAST   = CW'(OVS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_v0;
  logic                   r_v1;
  logic                   w_tick_run;

  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= Rx;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      r_cnt <= '0;
      r_v0  <= 1'b1;
      r_v1  <= 1'b1;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_tick_run) begin
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + CW'(1);
      if (r_cnt == c_MID_LO) r_v0 <= rx_s;
      if (r_cnt == c_MID)    r_v1 <= rx_s;
    end
  end

  assign rx_s       = r_sync[SYNC_STAGES-1];
  assign w_tick_run = Tick & cnt_run;
  assign start_edge = Tick & ~rx_s;
  assign bit_valid  = w_tick_run & (r_cnt == c_MID_HI);
  assign bit_end    = w_tick_run & (r_cnt == c_LAST);
  // Third vote is the live sample taken on the decision tick itself.
  assign bit_value  = (r_v0 & r_v1) | (r_v0 & rx_s) | (r_v1 & rx_s);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_param
// Runtime-configurable UART receiver with valid/ready output and error flags.
// Rev    : 1.0
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire        Clk,
  input  wire        Rst_n,
  input  wire        Tick,
  input  wire        RxEn,
  input  wire        Rx,
  input  wire  [3:0] NBits,
  input  wire        ParityEn,
  input  wire        ParityOdd,
  input  wire        TwoStop,
  uart_rx_param_if.master rx_if
);
  localparam logic [3:0] c_NMAX = (DATA_W > int'(c_NBITS_MAX)) ? c_NBITS_MAX : 4'(DATA_W);

  uart_state_t       r_state, w_next;
  logic [3:0]        r_nbits, r_bit_cnt;
  logic              r_par_en, r_par_odd, r_two_stop, r_stop_idx;
  logic              r_perr_p, r_ferr_p;
  logic [DATA_W-1:0] r_shift, r_data;
  logic              r_valid, r_perr, r_ferr, r_ovr, r_rxen_d;

  logic w_rx_s, w_start_edge, w_bit_valid, w_bit_value, w_bit_end, w_cnt_run;
  logic w_frame_start, w_sample_data, w_sample_par, w_sample_stop, w_frame_done;
  logic w_ferr_now, w_par_exp, w_accept;

  uart_rx_sampler #(.OVS(OVS), .SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Tick      (Tick),
    .Rx        (Rx),
    .cnt_clr   (w_frame_start),
    .cnt_run   (w_cnt_run),
    .rx_s      (w_rx_s),
    .start_edge(w_start_edge),
    .bit_valid (w_bit_valid),
    .bit_value (w_bit_value),
    .bit_end   (w_bit_end)
  );

  assign w_cnt_run  = RxEn && (r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
  assign w_ferr_now = r_ferr_p | ~w_bit_value;
  assign w_par_exp  = (^r_shift) ^ (r_par_odd == c_PAR_ODD);
  assign w_accept   = r_valid & rx_if.RxReady;

  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_frame_start = 1'b0;
    w_sample_data = 1'b0;
    w_sample_par  = 1'b0;
    w_sample_stop = 1'b0;
    w_frame_done  = 1'b0;
    if (!RxEn) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start_edge) begin
          w_next        = ST_START;
          w_frame_start = 1'b1;
        end
        ST_START: begin
          if (w_bit_valid && w_bit_value) w_next = ST_IDLE;
          else if (w_bit_end)             w_next = ST_DATA;
        end
        ST_DATA: begin
          w_sample_data = w_bit_valid;
          if (w_bit_end && r_bit_cnt == r_nbits) w_next = r_par_en ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          w_sample_par = w_bit_valid;
          if (w_bit_end) w_next = ST_STOP;
        end
        ST_STOP: if (w_bit_valid) begin
          w_sample_stop = 1'b1;
          // Frame completes on the decision tick of the final stop bit.
          if (r_stop_idx == r_two_stop) begin
            w_frame_done = 1'b1;
            w_next       = (w_ferr_now && !w_rx_s) ? ST_BREAK : ST_IDLE;
          end
        end
        ST_BREAK: if (Tick && w_rx_s) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      r_nbits    <= c_NBITS_MIN;
      r_par_en   <= 1'b0;
      r_par_odd  <= c_PAR_EVEN;
      r_two_stop <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_idx <= 1'b0;
      r_perr_p   <= 1'b0;
      r_ferr_p   <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_nbits    <= clamp_nbits(NBits, c_NMAX);
        r_par_en   <= ParityEn;
        r_par_odd  <= ParityOdd ? c_PAR_ODD : c_PAR_EVEN;
        r_two_stop <= TwoStop;
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_stop_idx <= 1'b0;
        r_perr_p   <= 1'b0;
        r_ferr_p   <= 1'b0;
      end
      if (w_sample_data) begin
        for (int i = 0; i < DATA_W; i++)
          if (r_bit_cnt == 4'(i)) r_shift[i] <= w_bit_value;
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_sample_par)  r_perr_p <= (w_bit_value != w_par_exp);
      if (w_sample_stop) r_ferr_p <= w_ferr_now;
      if (r_state == ST_STOP && w_bit_end) r_stop_idx <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      r_rxen_d <= 1'b0;
    end else begin
      r_rxen_d <= RxEn;
      if (w_frame_done) begin
        if (!r_valid || w_accept) begin
          r_data  <= r_shift;
          r_perr  <= r_perr_p;
          r_ferr  <= w_ferr_now;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (r_rxen_d && !RxEn) r_ovr <= 1'b0;
    end
  end

  assign rx_if.RxData    = r_data;
  assign rx_if.RxValid   = r_valid;
  assign rx_if.ParityErr = r_perr;
  assign rx_if.FrameErr  = r_ferr;
  assign rx_if.Overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_param
// Self-checking bench: directed frames plus randomized frames vs. a frame-level model.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int DATA_W      = 8;
  localparam int OVS         = 16;
  localparam int SYNC_STAGES = 2;

  logic       Clk = 1'b0, Rst_n = 1'b1, Tick = 1'b0, RxEn = 1'b0, Rx = 1'b1;
  logic [3:0] NBits = 4'd8;
  logic       ParityEn = 1'b0, ParityOdd = 1'b0, TwoStop = 1'b0;
  logic       ready_req = 1'b1, rand_ready = 1'b0;
  int         n_checks = 0, n_pass = 0, n_rx = 0, exp_rx = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;
  word_t exp_q[$];

  uart_rx_param_if #(.DATA_W(DATA_W)) rx_if ();

  uart_rx_param #(.DATA_W(DATA_W), .OVS(OVS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Tick     (Tick),
    .RxEn     (RxEn),
    .Rx       (Rx),
    .NBits    (NBits),
    .ParityEn (ParityEn),
    .ParityOdd(ParityOdd),
    .TwoStop  (TwoStop),
    .rx_if    (rx_if)
  );

  always #5 Clk = ~Clk;

  initial begin
    forever begin
      repeat (3) @(posedge Clk);
      #1 Tick = 1'b1;
      @(posedge Clk);
      #1 Tick = 1'b0;
    end
  end

  initial begin
    rx_if.RxReady = 1'b1;
    forever begin
      @(posedge Clk);
      #1 rx_if.RxReady = rand_ready ? 1'($urandom_range(0, 1)) : ready_req;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge Clk);
      while (Tick !== 1'b1) @(posedge Clk);
    end
  endtask

  task automatic send_bit(input logic b);
    #1 Rx = b;
    wait_ticks(OVS);
  endtask

  // Frame-level reference: effective length, masked data, parity and stop error outcome.
  task automatic send_frame(input logic [7:0] d, input logic [3:0] nb, input logic pe, input logic po,
                            input logic ts, input logic pflip, input logic [1:0] sbad, input bit push);
    int         neff;
    logic [7:0] dm;
    neff = (nb < 5) ? 5 : ((nb > DATA_W) ? DATA_W : int'(nb));
    dm   = 8'(d & ((1 << neff) - 1));
    #1;
    NBits = nb; ParityEn = pe; ParityOdd = po; TwoStop = ts;
    wait_ticks(3);
    if (push) begin
      exp_q.push_back('{data: dm, perr: pe & pflip, ferr: sbad[0] | (ts & sbad[1])});
      exp_rx++;
    end
    send_bit(1'b0);
    // Configuration must be frozen once the frame has started.
    NBits = 4'($urandom); ParityEn = 1'($urandom); ParityOdd = 1'($urandom); TwoStop = 1'($urandom);
    for (int i = 0; i < neff; i++) send_bit(dm[i]);
    if (pe) send_bit((^dm) ^ po ^ pflip);
    send_bit(!sbad[0]);
    if (ts) send_bit(!sbad[1]);
    #1 Rx = 1'b1;
  endtask

  initial begin : monitor
    word_t w;
    forever begin
      @(negedge Clk);
      if (!Rst_n && rx_if.RxValid && rx_if.RxReady) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_word", 32'(exp_q.size()), 32'd1);
        end else begin
          w = exp_q.pop_front();
          check_eq("rx_data", 32'(rx_if.RxData), 32'(w.data));
          check_eq("parity_err", 32'(rx_if.ParityErr), 32'(w.perr));
          check_eq("frame_err", 32'(rx_if.FrameErr), 32'(w.ferr));
        end
      end
    end
  end

  initial begin : main
    logic [1:0] sb;
    int         rx_snap;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_valid", 32'(rx_if.RxValid), 32'd0);
    check_eq("rst_data", 32'(rx_if.RxData), 32'd0);
    check_eq("rst_perr", 32'(rx_if.ParityErr), 32'd0);
    check_eq("rst_ferr", 32'(rx_if.FrameErr), 32'd0);
    check_eq("rst_ovr", 32'(rx_if.Overrun), 32'd0);
    check_eq("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    Rst_n = 1'b0;
    RxEn  = 1'b1;

    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    wait_ticks(OVS);
    check_eq("a5_words", 32'(n_rx), 32'(exp_rx));

    send_frame(8'h41, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    send_frame(8'h41, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    wait_ticks(OVS);
    check_eq("parity_words", 32'(n_rx), 32'(exp_rx));

    wait_ticks(2);
    #1 Rx = 1'b0;
    wait_ticks(4);
    #1 Rx = 1'b1;
    wait_ticks(2 * OVS);
    check_eq("false_start_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check_eq("false_start_words", 32'(n_rx), 32'(exp_rx));
    send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    send_frame(8'hC3, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1);
    wait_ticks(OVS);
    check_eq("stop2_words", 32'(n_rx), 32'(exp_rx));

    NBits = 4'd8; ParityEn = 1'b0; TwoStop = 1'b1;
    wait_ticks(3);
    exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
    exp_rx++;
    #1 Rx = 1'b0;
    wait_ticks(2 * 11 * OVS);
    check_eq("break_state", 32'(dut.r_state), 32'(ST_BREAK));
    check_eq("break_words", 32'(n_rx), 32'(exp_rx));
    #1 Rx = 1'b1;
    wait_ticks(2);
    check_eq("break_exit", 32'(dut.r_state), 32'(ST_IDLE));

    ready_req = 1'b0;
    rx_snap   = n_rx;
    send_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    send_frame(8'h22, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    wait_ticks(OVS);
    check_eq("ovr_valid", 32'(rx_if.RxValid), 32'd1);
    check_eq("ovr_data", 32'(rx_if.RxData), 32'h11);
    check_eq("ovr_flag", 32'(rx_if.Overrun), 32'd1);
    exp_q.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
    exp_rx++;
    ready_req = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("ovr_valid_drop", 32'(rx_if.RxValid), 32'd0);
    wait_ticks(4 * OVS);
    check_eq("ovr_one_word", 32'(n_rx - rx_snap), 32'd1);
    check_eq("ovr_sticky", 32'(rx_if.Overrun), 32'd1);
    RxEn = 1'b0;
    repeat (2) @(posedge Clk);
    #1 RxEn = 1'b1;
    @(posedge Clk);
    #1;
    check_eq("ovr_clear", 32'(rx_if.Overrun), 32'd0);

    NBits = 4'd8; ParityEn = 1'b0; TwoStop = 1'b0;
    wait_ticks(3);
    #1 Rx = 1'b0;
    wait_ticks(OVS);
    #1 Rx = 1'b1;
    wait_ticks(3 * OVS);
    check_eq("mid_data_state", 32'(dut.r_state), 32'(ST_DATA));
    #1 Rst_n = 1'b1;
    #2;
    check_eq("midrst_data", 32'(rx_if.RxData), 32'd0);
    check_eq("midrst_valid", 32'(rx_if.RxValid), 32'd0);
    check_eq("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
    @(posedge Clk);
    #1 Rst_n = 1'b0;
    send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    wait_ticks(OVS);
    check_eq("post_rst_words", 32'(n_rx), 32'(exp_rx));

    rand_ready = 1'b1;
    repeat (30) begin
      sb = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_frame(8'($urandom), 4'($urandom_range(3, 10)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), sb, 1'b1);
    end
    wait_ticks(2 * OVS);
    rand_ready = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("total_words", 32'(n_rx), 32'(exp_rx));
    check_eq("final_ovr", 32'(rx_if.Overrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, single-clock-domain UART receiver that replaces the fixed 8-bit, Tick-clocked receiver.
- Runtime-selectable data length, parity and stop-bit count.
- Oversampling ratio set by parameter; majority-voted mid-bit sampling.
- Valid/ready output handshake with parity, framing and overrun error flags.
- Sits between the baud tick generator and the command/FIFO logic of the serial link.

Parameters:
DATA_W, 8, maximum data bits per frame; legal 5..9.
OVS, 16, Tick pulses per bit period; even, >= 8.
SYNC_STAGES, 2, flip-flops in the Rx input synchroniser.

Ports:
Clk  input  1  system clock; all logic on posedge Clk.
Rst_n  input  1  reset, asynchronous, active-high.
Tick  input  1  oversample enable, one Clk wide, OVS per bit period.
RxEn  input  1  receiver enable.
Rx  input  1  serial line, asynchronous; idle high.
NBits  input  4  data bits per frame (5..DATA_W).
ParityEn  input  1  1 = parity bit present.
ParityOdd  input  1  1 = odd parity, 0 = even.
TwoStop  input  1  1 = two stop bits.
RxData  output  DATA_W  received word, LSB-first, right-justified, upper bits zero.
RxValid  output  1  word available; held until accepted.
RxReady  input  1  consumer accepts when RxValid && RxReady.
ParityErr  output  1  parity mismatch on the word in RxData.
FrameErr  output  1  stop bit sampled low on the word in RxData.
Overrun  output  1  sticky; a frame completed while RxValid was pending.

Behaviour:
- Reset: state IDLE, counters 0, synchroniser = 1, RxData = 0, RxValid = ParityErr = FrameErr = Overrun = 0.
- Rx passes through the SYNC_STAGES synchroniser; all references to Rx below mean the synchronised value.
- The tick counter advances only on Tick. Sampling uses a 3-sample majority vote at tick counts OVS/2-1, OVS/2 and OVS/2+1. The bit decision is taken at count OVS/2+1. The bit period ends at count OVS-1, and the counter wraps to 0.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when RxEn=1 and Rx=0 on a Tick, go to START with count=0. Latch NBits, ParityEn, ParityOdd and TwoStop; these are frozen for the whole frame.
  - START: if the voted start bit is 1, this is a false start; return to IDLE with no output. Otherwise go to DATA at the end of the bit period.
  - DATA: shift in NBits bits, LSB first. Then go to PARITY if ParityEn=1, else STOP.
  - PARITY: the voted bit is compared against the XOR of the data bits, inverted when ParityOdd=1. A mismatch sets the pending parity error.
  - STOP: with TwoStop=1, both stop bits are checked. Any voted 0 sets the pending frame error. Completion occurs at the decision tick of the last stop bit, not at the end of that bit period.
  - At completion, go to IDLE. If a frame error occurred and Rx=0, go to BREAK instead.
  - BREAK: wait for Rx=1 sampled on a Tick, then go to IDLE. No new start is detected while in BREAK.
- Out-of-range NBits: values below 5 are treated as 5; values above DATA_W are treated as DATA_W.
- Output latency: RxValid rises the Clk cycle after the completing Tick. RxData, ParityErr and FrameErr update in the same cycle.
- Handshake: RxValid stays high until RxValid&&RxReady, then drops the next cycle. RxData and the error flags are held while RxValid=1.
- Overrun: if a frame completes while RxValid=1 and not being accepted that same cycle, the new word is discarded, the existing RxData is kept, and Overrun is set. Overrun clears only on reset or on RxEn falling.
  - Acceptance and completion in the same cycle: the new word is loaded, RxValid stays 1, and there is no overrun.
- RxEn deasserted mid-frame: abort to IDLE on the next Clk and discard the partial word. A pending RxValid is unaffected.
- Reset asserted mid-frame: immediate return to the reset values above.

Decomposition:
- Shared package uart_pkg:
  - state enum/localparams (IDLE, START, DATA, PARITY, STOP, BREAK);
  - parity-mode constants;
  - the NBits min/max clamp constants, also used by the transmitter.
- One natural sub-module: uart_rx_sampler. It contains the synchroniser, the tick counter and the majority vote, and outputs bit_valid pulses, bit_value and start_edge.

Test Plan:
- OVS=16, 8N1, send 0xA5, RxReady=1 -> one RxValid pulse, RxData=0xA5, no error flags.
- 7 bits, even parity, send 0x41 with parity bit 0 -> RxData=0x41, ParityErr=0. Repeat with parity bit 1 -> ParityErr=1, RxData=0x41.
- Rx low for 4 Ticks, then high -> no frame, state returns to IDLE. A following 0x3C frame is received correctly.
- 8N2, second stop bit driven 0 -> RxData delivered with FrameErr=1. Hold Rx low for 2 frame times -> exactly one word is delivered and the block stays in BREAK until Rx=1.
- RxReady=0, send 0x11 then 0x22 -> RxData=0x11, Overrun=1. After RxReady=1, RxValid drops and no 0x22 word appears.
- Assert Rst_n mid-DATA of 0xFF -> all outputs 0 immediately. The next frame, 0x5A, is received correctly.
